// File: rtl/dsp_4bits_alu_driver_if.sv
// Host-side command and response channels
// of the 4-bit ALU nibble driver.
interface dsp_4bits_alu_driver_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op1;
  logic [3:0] cmd_op2;
  logic [3:0] cmd_opcode;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_result;
  logic [2:0] rsp_flags;
  logic       rsp_error;
  logic       busy;

  modport master (
    output cmd_valid,
    output cmd_op1,
    output cmd_op2,
    output cmd_opcode,
    output rsp_ready,
    input  cmd_ready,
    input  rsp_valid,
    input  rsp_result,
    input  rsp_flags,
    input  rsp_error,
    input  busy
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op1,
    input  cmd_op2,
    input  cmd_opcode,
    input  rsp_ready,
    output cmd_ready,
    output rsp_valid,
    output rsp_result,
    output rsp_flags,
    output rsp_error,
    output busy
  );
endinterface

// File: rtl/dsp_4bits_alu_driver.sv
// Serialises a parallel ALU command into the nibble protocol.
// Optional done watchdog: define ALU_DRV_WATCHDOG_EN.
module dsp_4bits_alu_driver #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  dsp_4bits_alu_driver_if.slave        host,
  output logic                         alu_reset,
  output logic                         alu_enable,
  output logic [3:0]                   alu_data,
  input  logic [3:0]                   alu_result,
  input  logic [3:0]                   alu_flags
);

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    SEND_OP1,
    SEND_OP2,
    SEND_OPC,
    EXEC,
    WAIT_DONE,
    RESP
  } state_e;

  state_e     state_q, state_d;
  logic       init_q, init_d;
  logic [3:0] op2_q, op2_d;
  logic [3:0] opc_q, opc_d;
  logic       err_q, err_d;
  logic       rst_q, rst_d;
  logic       en_q, en_d;
  logic [3:0] data_q, data_d;
  logic       crdy_q, crdy_d;
  logic       rvld_q, rvld_d;
  logic [3:0] res_q, res_d;
  logic [2:0] flg_q, flg_d;
  logic       busy_q, busy_d;
  logic       wd_expired;

`ifdef ALU_DRV_WATCHDOG_EN
  localparam int unsigned WD_W =
    (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [WD_W-1:0] wd_q, wd_d;

  assign wd_expired = (wd_q == WD_W'(TIMEOUT - 1));

  always_comb begin
    wd_d = '0;
    if (state_q == WAIT_DONE) begin
      wd_d = wd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end

  assign host.rsp_error = err_q;
`else
  localparam int unsigned unused_timeout = TIMEOUT;

  assign wd_expired     = 1'b0;
  assign host.rsp_error = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    init_d  = 1'b0;
    op2_d   = op2_q;
    opc_d   = opc_q;
    err_d   = err_q;
    res_d   = res_q;
    flg_d   = flg_q;
    data_d  = 4'h0;
    unique case (state_q)
      INIT: begin
        init_d = 1'b1;
        if (init_q) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (host.cmd_valid && crdy_q) begin
          state_d = SEND_OP1;
          op2_d   = host.cmd_op2;
          opc_d   = host.cmd_opcode;
          data_d  = host.cmd_op1;
        end
      end
      SEND_OP1: begin
        state_d = SEND_OP2;
        data_d  = op2_q;
      end
      SEND_OP2: begin
        state_d = SEND_OPC;
        data_d  = opc_q;
      end
      SEND_OPC: begin
        state_d = EXEC;
      end
      EXEC: begin
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (alu_flags[0]) begin
          state_d = RESP;
          res_d   = alu_result;
          flg_d   = alu_flags[3:1];
          err_d   = 1'b0;
        end else if (wd_expired) begin
          state_d = RESP;
          res_d   = 4'h0;
          flg_d   = 3'b000;
          err_d   = 1'b1;
        end
      end
      RESP: begin
        if (host.rsp_ready) begin
          // an error leaves the ALU out of step, so re-reset it
          state_d = err_q ? INIT : IDLE;
          err_d   = 1'b0;
        end
      end
    endcase

    rst_d  = (state_d == INIT);
    crdy_d = (state_d == IDLE);
    rvld_d = (state_d == RESP);
    busy_d = (state_d != IDLE);
    en_d   = state_d inside {SEND_OP1, SEND_OP2,
                             SEND_OPC, EXEC};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= INIT;
      init_q  <= 1'b0;
      op2_q   <= 4'h0;
      opc_q   <= 4'h0;
      err_q   <= 1'b0;
      rst_q   <= 1'b1;
      en_q    <= 1'b0;
      data_q  <= 4'h0;
      crdy_q  <= 1'b0;
      rvld_q  <= 1'b0;
      res_q   <= 4'h0;
      flg_q   <= 3'b000;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      op2_q   <= op2_d;
      opc_q   <= opc_d;
      err_q   <= err_d;
      rst_q   <= rst_d;
      en_q    <= en_d;
      data_q  <= data_d;
      crdy_q  <= crdy_d;
      rvld_q  <= rvld_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
      busy_q  <= busy_d;
    end
  end

  assign alu_reset       = rst_q;
  assign alu_enable      = en_q;
  assign alu_data        = data_q;
  assign host.cmd_ready  = crdy_q;
  assign host.rsp_valid  = rvld_q;
  assign host.rsp_result = res_q;
  assign host.rsp_flags  = flg_q;
  assign host.busy       = busy_q;

endmodule
